// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer slice.
// Holds the timer state encoding and the default widths used by the
// timer top and its prescaler.
package timer_pkg;

  localparam int COUNT_WIDTH_DEF    = 16;
  localparam int PRESCALE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer_prescaler_tick.sv
// Prescaler for the countdown timer.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   load   - force the divider counter to ratio (start, or ratio=0 on abort)
//   enable - advance the divider this cycle (RUN and not paused)
//   ratio  - value reloaded into the divider on load and on every tick
//   tick   - one-cycle pulse when an enabled divider counter sits at zero
module prescaler_tick
  import timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] ratio,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] presc_cnt_q;
  logic [PRESCALE_WIDTH-1:0] presc_cnt_d;

  // Next divider value and tick; load beats enable so an abort never ticks.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    tick        = 1'b0;
    if (load) begin
      presc_cnt_d = ratio;
    end else if (enable) begin
      if (presc_cnt_q == {PRESCALE_WIDTH{1'b0}}) begin
        tick        = 1'b1;
        presc_cnt_d = ratio;
      end else begin
        presc_cnt_d = presc_cnt_q - PRESCALE_WIDTH'(1);
      end
    end else begin
      presc_cnt_d = presc_cnt_q;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_q <= {PRESCALE_WIDTH{1'b0}};
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with programmable prescaler.
// Counts load_value down once every (prescale+1) cycles and pulses expired
// for one cycle at terminal count; optionally reloads for periodic use.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start             - launch (honoured only when idle)
//   abort             - stop immediately, no expiry
//   pause             - level; freezes count and prescaler phase
//   auto_reload       - periodic mode, sampled at start
//   load_value        - initial/reload count, sampled at start
//   prescale          - divide ratio minus one, sampled at start
//   count, busy, expired - registered status outputs
module countdown_timer
  import timer_pkg::*;
#(
  parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      pause,
  input  logic                      auto_reload,
  input  logic [COUNT_WIDTH-1:0]    load_value,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [COUNT_WIDTH-1:0]    count,
  output logic                      busy,
  output logic                      expired
);

  timer_state_t              state_q, state_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    reload_val_q, reload_val_d;
  logic [PRESCALE_WIDTH-1:0] presc_lat_q, presc_lat_d;
  logic                      ar_lat_q, ar_lat_d;
  logic                      busy_q, busy_d;
  logic                      expired_q, expired_d;

  logic                      start_accept_s;
  logic                      presc_load_s;
  logic                      presc_enable_s;
  logic [PRESCALE_WIDTH-1:0] presc_ratio_s;
  logic                      tick_s;

  // Prescaler control: start seeds the live prescale input (not yet latched),
  // abort clears the divider, otherwise ticks reload from the latched ratio.
  always_comb begin
    start_accept_s = start && !abort && (state_q == IDLE)
                     && (load_value != {COUNT_WIDTH{1'b0}});
    presc_load_s   = abort || start_accept_s;
    presc_enable_s = (state_q == RUN) && !pause;
    if (abort) begin
      presc_ratio_s = {PRESCALE_WIDTH{1'b0}};
    end else if (start_accept_s) begin
      presc_ratio_s = prescale;
    end else begin
      presc_ratio_s = presc_lat_q;
    end
  end

  prescaler_tick #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler_tick (
    .clk    (clk),
    .reset  (reset),
    .load   (presc_load_s),
    .enable (presc_enable_s),
    .ratio  (presc_ratio_s),
    .tick   (tick_s)
  );

  // Next-state, count and expiry logic; abort overrides everything but reset.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reload_val_d = reload_val_q;
    presc_lat_d  = presc_lat_q;
    ar_lat_d     = ar_lat_q;
    expired_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_accept_s) begin
            count_d      = load_value;
            reload_val_d = load_value;
            presc_lat_d  = prescale;
            ar_lat_d     = auto_reload;
            state_d      = RUN;
          end else if (start) begin
            // Zero-length run: report expiry at once without leaving IDLE.
            expired_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick_s) begin
            if (count_q == COUNT_WIDTH'(1)) begin
              expired_d = 1'b1;
              if (ar_lat_q) begin
                count_d = reload_val_q;
              end else begin
                count_d = {COUNT_WIDTH{1'b0}};
                state_d = IDLE;
              end
            end else if (count_q != {COUNT_WIDTH{1'b0}}) begin
              count_d = count_q - COUNT_WIDTH'(1);
            end else begin
              // RUN never holds zero; hold rather than wrap if it ever did.
              count_d = count_q;
            end
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = {COUNT_WIDTH{1'b0}};
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, count, latches and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= {COUNT_WIDTH{1'b0}};
      reload_val_q <= {COUNT_WIDTH{1'b0}};
      presc_lat_q  <= {PRESCALE_WIDTH{1'b0}};
      ar_lat_q     <= 1'b0;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_val_q <= reload_val_d;
      presc_lat_q  <= presc_lat_d;
      ar_lat_q     <= ar_lat_d;
      busy_q       <= busy_d;
      expired_q    <= expired_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer. Expected expiry events (cycle and
// count) are queued when a run is launched; a monitor pops one per expired
// pulse. Count/busy traces are checked directly against hand-derived values.
module tb_countdown_timer;

  localparam int CW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          pause;
  logic          auto_reload;
  logic [CW-1:0] load_value;
  logic [PW-1:0] prescale;
  logic [CW-1:0] count;
  logic          busy;
  logic          expired;

  countdown_timer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_value  (load_value),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cyc_q[$];
  int exp_cnt_q[$];
  bit mon_on = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int c, input int n);
    exp_cyc_q.push_back(c);
    exp_cnt_q.push_back(n);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge (k=0).
  task automatic do_start(input int lv, input int ps, input bit ar, output int sc);
    load_value  = CW'(lv);
    prescale    = PW'(ps);
    auto_reload = ar;
    start       = 1'b1;
    sc          = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard monitor: every expired pulse must match the oldest expectation.
  int mon_ec;
  int mon_en;
  always @(negedge clk) begin
    if (mon_on && expired) begin
      if (exp_cyc_q.size() == 0) begin
        check("unexpected_expired", cyc, -1);
      end else begin
        mon_ec = exp_cyc_q.pop_front();
        mon_en = exp_cnt_q.pop_front();
        check("expiry_cycle", cyc, mon_ec);
        check("expiry_count", int'(count), mon_en);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    auto_reload = 1'b0; load_value = '0; prescale = '0;
    repeat (3) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_expired", int'(expired), 0);
    reset = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles mid-run at count 7.
    do_start(10, 0, 1'b0, sc);
    repeat (3) @(negedge clk);
    check("midrun_count", int'(count), 7);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_expired", int'(expired), 0);
    @(negedge clk);
    check("midrst_idle_busy", int'(busy), 0);

    // One-shot N=5, P=0: 5,4,3,2,1,0 with expiry 5 cycles after start.
    do_start(5, 0, 1'b0, sc);
    push_exp(sc + 5, 0);
    for (int k = 0; k <= 5; k++) begin
      check("oneshot_count", int'(count), 5 - k);
      check("oneshot_busy", int'(busy), (k < 5) ? 1 : 0);
      if (k < 5) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Periodic N=3, P=2: period 9, never shows 0; abort after two periods.
    do_start(3, 2, 1'b1, sc);
    push_exp(sc + 9, 3);
    push_exp(sc + 18, 3);
    for (int k = 0; k <= 18; k++) begin
      check("periodic_count", int'(count), 3 - ((k % 9) / 3));
      if (k < 18) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_count", int'(count), 0);
    check("abort_busy", int'(busy), 0);
    repeat (20) @(negedge clk);

    // Pause: N=4, P=1. Pause sampled high on 4 edges plus the resume edge
    // freezes 5 cycles, so expiry moves from 8 to 13.
    do_start(4, 1, 1'b0, sc);
    push_exp(sc + 13, 0);
    repeat (3) @(negedge clk);
    check("pause_pre_count", int'(count), 3);
    pause = 1'b1;
    repeat (4) @(negedge clk);
    pause = 1'b0;
    check("pause_frozen_count", int'(count), 3);
    check("pause_busy", int'(busy), 1);
    @(negedge clk);
    check("pause_resume_count", int'(count), 3);
    @(negedge clk);
    check("pause_after_count", int'(count), 2);
    repeat (6) @(negedge clk);
    check("pause_done_busy", int'(busy), 0);
    check("pause_done_count", int'(count), 0);

    // Zero load: immediate expiry, stays idle.
    push_exp(cyc + 1, 0);
    do_start(0, 0, 1'b0, sc);
    check("zero_busy", int'(busy), 0);
    check("zero_count", int'(count), 0);
    @(negedge clk);
    check("zero_after_busy", int'(busy), 0);

    // Start while busy is ignored.
    do_start(6, 0, 1'b0, sc);
    push_exp(sc + 6, 0);
    load_value = CW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("busy_start_count", int'(count), 6 - k);
      if (k < 6) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Start and abort together in idle: abort wins.
    load_value = CW'(5); prescale = '0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", int'(busy), 0);
    check("startabort_count", int'(count), 0);
    @(negedge clk);
    check("startabort_busy2", int'(busy), 0);

    // Full-scale load: 65535 cycles, no wrap.
    do_start(65535, 0, 1'b0, sc);
    push_exp(sc + 65535, 0);
    check("max_count0", int'(count), 65535);
    @(negedge clk);
    check("max_count1", int'(count), 65534);
    repeat (65533) @(negedge clk);
    check("max_last_count", int'(count), 1);
    check("max_last_busy", int'(busy), 1);
    @(negedge clk);
    check("max_end_count", int'(count), 0);
    check("max_end_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("max_idle_count", int'(count), 0);

    check("pending_expiries", exp_cyc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
